// File: rtl/sc_sub_sequencer.sv
// Stochastic-computing scaled subtracter: three LFSR-driven bitstreams form
// (a + (1-b))/2 as a 2^CNT_LOG2-cycle stream whose 1s are counted into result.
module sc_sub_sequencer #(
   parameter int WIDTH    = 8,   // operand/LFSR width; the tap set is fixed for 8 bits
   parameter int CNT_LOG2 = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [WIDTH-1:0]    a_val,
   input  logic [WIDTH-1:0]    b_val,
   output logic                busy,
   output logic                done,
   output logic [CNT_LOG2:0]   result,
   output logic                s_out
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FLUSH,
      S_DONE
   } state_t;

   localparam logic [WIDTH-1:0]    SEED_A    = WIDTH'(8'h01);
   localparam logic [WIDTH-1:0]    SEED_B    = WIDTH'(8'h5A);
   localparam logic [WIDTH-1:0]    SEED_S    = WIDTH'(8'hB4);
   localparam logic [WIDTH-1:0]    SC_THRESH = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_LOG2-1:0] CNT_LAST  = '1;

   state_t               r_state;
   state_t               w_state_next;
   logic                 w_accept;

   logic [WIDTH-1:0]     r_a_lat;
   logic [WIDTH-1:0]     r_b_lat;
   logic [WIDTH-1:0]     r_lfsr_a;
   logic [WIDTH-1:0]     r_lfsr_b;
   logic [WIDTH-1:0]     r_lfsr_s;
   logic [CNT_LOG2-1:0]  r_cnt;
   logic [CNT_LOG2:0]    r_acc;
   logic [CNT_LOG2:0]    r_result;
   logic                 r_s_out;
   logic                 r_add_en;

   logic                 w_sa;
   logic                 w_sb;
   logic                 w_sc;
   logic                 w_s_bit;
   logic [CNT_LOG2:0]    w_acc_next;

   // Fibonacci step for x^8+x^6+x^5+x^4+1: shift left, feedback into bit 0.
   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   always_comb begin
      // NOTE: defaults first so every path assigns each output; otherwise a latch is inferred.
      w_state_next = r_state;
      w_accept     = 1'b0;
      busy         = (r_state != S_IDLE);
      done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (r_cnt == CNT_LAST) w_state_next = S_FLUSH;
         end
         S_FLUSH: begin
            w_state_next = S_DONE;
         end
         S_DONE: begin
            done         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Unipolar stream bits; sc selects between a and the complement of b.
   assign w_sa       = (r_lfsr_a < r_a_lat);
   assign w_sb       = (r_lfsr_b < r_b_lat);
   assign w_sc       = (r_lfsr_s < SC_THRESH);
   assign w_s_bit    = (~w_sc & w_sa) | (w_sc & ~w_sb);
   assign w_acc_next = r_acc + {{CNT_LOG2{1'b0}}, r_s_out};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         // NOTE: non-blocking so every register updates from the pre-edge values.
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_lat  <= '0;
         r_b_lat  <= '0;
         r_lfsr_a <= SEED_A;
         r_lfsr_b <= SEED_B;
         r_lfsr_s <= SEED_S;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_s_out  <= 1'b0;
         r_add_en <= 1'b0;
      end else begin
         // s_out lags the compare by one cycle, so the add trails RUN by one and
         // its last term lands in FLUSH.
         r_add_en <= (r_state == S_RUN);
         if (r_add_en) begin
            r_acc <= w_acc_next;
         end
         if (r_state == S_FLUSH) begin
            r_result <= w_acc_next;
         end

         if (r_state == S_RUN) begin
            r_s_out  <= w_s_bit;
            r_lfsr_a <= lfsr_step(r_lfsr_a);
            r_lfsr_b <= lfsr_step(r_lfsr_b);
            r_lfsr_s <= lfsr_step(r_lfsr_s);
            r_cnt    <= r_cnt + CNT_LOG2'(1);
         end

         if (w_accept) begin
            r_a_lat  <= a_val;
            r_b_lat  <= b_val;
            r_lfsr_a <= SEED_A;
            r_lfsr_b <= SEED_B;
            r_lfsr_s <= SEED_S;
            r_cnt    <= '0;
            r_acc    <= '0;
         end
      end
   end

   assign result = r_result;
   assign s_out  = r_s_out;

endmodule
